// File: rtl/multi_state_machine.sv
// One-hot state selector with per-state requests, minimum-dwell lockout,
// priority or round-robin arbitration, sticky hold, enable gate and dwell counter.
module multi_state_machine #(
  parameter int unsigned N_STATES    = 3,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned MIN_DWELL   = 4,
  parameter int unsigned DWELL_W     = 8,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned MODE        = 0,
  parameter int unsigned STICKY      = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [N_STATES-1:0] req_i,
  output logic [N_STATES-1:0] state_o,
  output logic [IDX_W-1:0]    state_idx_o,
  output logic                changed_o,
  output logic [DWELL_W-1:0]  dwell_cnt_o
);

  localparam logic [N_STATES-1:0] RstOneHot = N_STATES'(1) << RESET_STATE;
  localparam logic [IDX_W-1:0]    RstIdx    = IDX_W'(RESET_STATE);

  logic [N_STATES-1:0] state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                changed_q, changed_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;

  logic [IDX_W-1:0]    target;
  logic                found;
  logic                locked;
  int unsigned         rr_k;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RstOneHot;
      idx_q     <= RstIdx;
      changed_q <= 1'b0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      changed_q <= changed_d;
      dwell_q   <= dwell_d;
    end
  end

  // Target selection and next-state
  always_comb begin
    target    = idx_q;
    found     = 1'b0;
    rr_k      = 0;
    locked    = 32'(dwell_q) < MIN_DWELL;
    state_d   = state_q;
    idx_d     = idx_q;
    dwell_d   = dwell_q;
    changed_d = 1'b0;

    if (req_i == '0) begin
      target = idx_q;
    end else if ((STICKY != 0) && req_i[idx_q]) begin
      target = idx_q;
    end else if (MODE == 0) begin
      for (int k = 0; k < int'(N_STATES); k++) begin
        if (!found && req_i[k]) begin
          target = IDX_W'(k);
          found  = 1'b1;
        end
      end
    end else begin
      // Search starts just above cur and wraps, ending at cur itself.
      for (int i = 1; i <= int'(N_STATES); i++) begin
        rr_k = 32'(idx_q) + 32'(i);
        if (rr_k >= N_STATES) rr_k = rr_k - N_STATES;
        if (!found && req_i[rr_k]) begin
          target = IDX_W'(rr_k);
          found  = 1'b1;
        end
      end
    end

    if (en_i) begin
      if ((target != idx_q) && !locked) begin
        state_d         = '0;
        state_d[target] = 1'b1;
        idx_d           = target;
        dwell_d         = '0;
        changed_d       = 1'b1;
      end else if (dwell_q != '1) begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
  end

  // Outputs are straight from registers
  always_comb begin
    state_o     = state_q;
    state_idx_o = idx_q;
    changed_o   = changed_q;
    dwell_cnt_o = dwell_q;
  end

endmodule
